lab3_2_sched: RTL and testbench
===============================

# lab3_2_sched

Controller and round-robin arbiter that shares one prime/non-prime digit datapath between two requesters, A and B. It accepts one operation at a time over a valid/ready handshake and drives the datapath for exactly one enabled cycle. It then captures the datapath's digit and warning outputs and returns them on a response handshake. It also sequences datapath clears and locks out a requester that produces too many consecutive warnings.

## Interface
- ERR_LIMIT, default 3: number of consecutive warning responses that blocks a requester (range 1..15).
- CLK  in  1  single clock; all state changes on its rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- a_valid / b_valid  in  1  requester has an operation.
- a_ready / b_ready  out  1  operation accepted on CLK edge when valid&ready.
- a_number / b_number  in  4  operand.
- a_selection / b_selection  in  1  0 = prime class, 1 = non-prime class.
- a_mode / b_mode  in  1  0 = previous/shift-right, 1 = next/shift-left.
- a_blocked / b_blocked  out  1  requester locked out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed on edge when rsp_valid&rsp_ready.
- rsp_id  out  1  0 = A, 1 = B.
- rsp_digit1 / rsp_digit0  out  8  captured datapath digits.
- rsp_warning  out  1  captured datapath warning.
- clr_req  in  1  request for a datapath clear (sticky until serviced).
- clr_done  out  1  one-cycle pulse when the clear has completed.
- dp_en  out  1  datapath sample enable; the datapath holds all state while dp_en=0.
- dp_clear, dp_selection, dp_mode  out  1  datapath controls.
- dp_number  out  4  datapath operand.
- dp_digit1 / dp_digit0  in  8  datapath digit outputs.
- dp_warning  in  1  datapath warning output.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP, CLEAR.
- clr_pend = clr_req | clr_latch. clr_latch is set whenever clr_req=1 outside IDLE, and cleared on entry to CLEAR.
- IDLE with clr_pend -> CLEAR. Clear has priority over requests, so both readys are 0.
- IDLE otherwise, arbitration:
  - Eligible requester = valid & !blocked.
  - If both are eligible, grant the one not served last. last_served resets to B, so A wins first.
  - Only the granted requester sees ready=1.
  - Ready depends on state, blocked, clr_pend, last_served and the other requester's valid, never on its own valid.
- Accept: on the handshake edge, register {id, number, selection, mode} into the op register and move to ISSUE.
- ISSUE (1 cycle): dp_en=1, dp_clear=0, dp_* driven from the op register. -> CAPTURE.
- CAPTURE (1 cycle): dp_en=0. On the end edge:
  - Register dp_digit1, dp_digit0 and dp_warning into rsp_*.
  - Update the consecutive-warning counter for the op id. warning=1 increments it, saturating at ERR_LIMIT. warning=0 zeroes it.
  - The counter reaching ERR_LIMIT sets that requester's blocked bit.
  - Go to RESP.
- RESP: rsp_valid=1 with stable rsp_* until rsp_ready. The handshake edge sets last_served=id and returns to IDLE.
- CLEAR (1 cycle): dp_en=1, dp_clear=1. The end edge zeroes both warning counters and both blocked bits, then returns to IDLE. clr_done=1 during the first IDLE cycle after CLEAR.
- Blocked requester: ready stays 0. Its valid is ignored by the arbiter, and only a CLEAR unblocks it.
- dp_number, dp_selection and dp_mode are 0 whenever dp_en=0.

## Timing
- Reset (clear_n=0, asynchronous):
  - State IDLE; last_served=B; clr_latch, counters and blocked bits all 0.
  - Outputs 0: rsp_*, clr_done, dp_* and *_blocked.
  - A reset mid-transaction drops the in-flight op with no response.
- Accept edge at cycle t: ISSUE in t+1, CAPTURE in t+2, rsp_valid=1 from t+3.
- Next accept is possible in the cycle after the response handshake. Throughput with rsp_ready held 1 is one op per 4 cycles.
- clr_req in IDLE: CLEAR in the next cycle, clr_done one cycle later (2 cycles after the request edge).
- clr_req during ISSUE/CAPTURE/RESP: the current op completes normally, and CLEAR follows the RESP handshake.
- Simultaneous clr_req and valid in IDLE: clear wins, and the request waits.
- A warning that reaches ERR_LIMIT: blocked rises at the CAPTURE end edge, visible together with rsp_valid.

## Test plan
- Single op: A sends number=5, sel=0, mode=1, and the datapath returns digit1=11, digit0=5, warn=0 -> dp_en high exactly one cycle; rsp_valid 3 cycles after accept with id=0, 11/5/0.
- Contention: A and B valid continuously with rsp_ready=1 -> grants alternate A,B,A,B; each response id matches; exactly one dp_en pulse per op.
- Lockout: B sends number=4 with sel=0 three times (datapath warns) -> b_blocked=1 after the third CAPTURE; b_ready stays 0 while A continues to be served.
- Clear: clr_req pulsed during A's CAPTURE -> A's response is delivered; then a CLEAR cycle with dp_en=dp_clear=1, a clr_done pulse, and b_blocked back to 0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable; no dp_en; both readys 0.
- Async reset asserted in ISSUE -> all outputs 0 immediately; after release the first grant goes to A.

Source files
------------

// File: rtl/lab3_2_sched_if.sv
// Requester and response handshake bundle for lab3_2_sched.
// master = requester/consumer side, slave = scheduler side.
interface lab3_2_sched_if;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] a_number;
  logic       a_selection;
  logic       a_mode;
  logic       a_blocked;

  logic       b_valid;
  logic       b_ready;
  logic [3:0] b_number;
  logic       b_selection;
  logic       b_mode;
  logic       b_blocked;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_digit1;
  logic [7:0] rsp_digit0;
  logic       rsp_warning;

  modport master (
    output a_valid, a_number, a_selection, a_mode,
    output b_valid, b_number, b_selection, b_mode,
    output rsp_ready,
    input  a_ready, a_blocked, b_ready, b_blocked,
    input  rsp_valid, rsp_id, rsp_digit1, rsp_digit0, rsp_warning
  );

  modport slave (
    input  a_valid, a_number, a_selection, a_mode,
    input  b_valid, b_number, b_selection, b_mode,
    input  rsp_ready,
    output a_ready, a_blocked, b_ready, b_blocked,
    output rsp_valid, rsp_id, rsp_digit1, rsp_digit0, rsp_warning
  );
endinterface

// File: rtl/lab3_2_sched.sv
// Round-robin scheduler sharing one prime/non-prime digit datapath between
// requesters A and B, with clear sequencing and per-requester warning lockout.
module lab3_2_sched #(
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic       CLK,
  input  logic       clear_n,
  lab3_2_sched_if.slave bus,
  input  logic       clr_req,
  output logic       clr_done,
  output logic       dp_en,
  output logic       dp_clear,
  output logic       dp_selection,
  output logic       dp_mode,
  output logic [3:0] dp_number,
  input  logic [7:0] dp_digit1,
  input  logic [7:0] dp_digit0,
  input  logic       dp_warning
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, CLEAR} state_t;

  localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

  state_t     state, state_nx;

  logic       last_served;   // 0 = A, 1 = B
  logic       clr_latch;
  logic       clr_pend;
  logic       clr_done_q;

  logic       op_id;
  logic [3:0] op_num;
  logic       op_sel;
  logic       op_mode;

  logic [3:0] cnt_a, cnt_b;
  logic [3:0] cnt_cur, cnt_nx;
  logic       blk_a, blk_b;

  logic [7:0] rsp_d1, rsp_d0;
  logic       rsp_warn;
  logic       rsp_id_q;

  logic       elig_a, elig_b;
  logic       rdy_a, rdy_b;
  logic       take_a, take_b;
  logic       rsp_fire;

  assign clr_pend = clr_req | clr_latch;
  assign elig_a   = bus.a_valid & ~blk_a;
  assign elig_b   = bus.b_valid & ~blk_b;

  // A requester's ready never looks at its own valid, only at the other side's.
  always_comb begin
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    if (state == IDLE && !clr_pend) begin
      rdy_a = ~blk_a & (~elig_b |  last_served);
      rdy_b = ~blk_b & (~elig_a | ~last_served);
    end
  end

  assign take_a   = bus.a_valid & rdy_a;
  assign take_b   = bus.b_valid & rdy_b;
  assign rsp_fire = (state == RESP) & bus.rsp_ready;

  // State register
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (clr_pend)              state_nx = CLEAR;
        else if (take_a || take_b) state_nx = ISSUE;
      end
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    dp_en        = 1'b0;
    dp_clear     = 1'b0;
    dp_number    = '0;
    dp_selection = 1'b0;
    dp_mode      = 1'b0;
    unique case (state)
      ISSUE: begin
        dp_en        = 1'b1;
        dp_number    = op_num;
        dp_selection = op_sel;
        dp_mode      = op_mode;
      end
      CLEAR: begin
        dp_en    = 1'b1;
        dp_clear = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.a_ready     = rdy_a;
  assign bus.b_ready     = rdy_b;
  assign bus.a_blocked   = blk_a;
  assign bus.b_blocked   = blk_b;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_digit1  = rsp_d1;
  assign bus.rsp_digit0  = rsp_d0;
  assign bus.rsp_warning = rsp_warn;
  assign clr_done        = clr_done_q;

  // Saturating consecutive-warning count for the op being captured.
  always_comb begin
    cnt_cur = op_id ? cnt_b : cnt_a;
    cnt_nx  = '0;
    if (dp_warning) cnt_nx = (cnt_cur >= LIMIT) ? LIMIT : cnt_cur + 4'd1;
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      last_served <= 1'b1;
      clr_latch   <= 1'b0;
      clr_done_q  <= 1'b0;
      op_id       <= 1'b0;
      op_num      <= '0;
      op_sel      <= 1'b0;
      op_mode     <= 1'b0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      blk_a       <= 1'b0;
      blk_b       <= 1'b0;
      rsp_d1      <= '0;
      rsp_d0      <= '0;
      rsp_warn    <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      clr_done_q <= (state == CLEAR);

      if (state == IDLE && clr_pend) clr_latch <= 1'b0;
      else if (state != IDLE && clr_req) clr_latch <= 1'b1;

      if (take_a) begin
        op_id   <= 1'b0;
        op_num  <= bus.a_number;
        op_sel  <= bus.a_selection;
        op_mode <= bus.a_mode;
      end else if (take_b) begin
        op_id   <= 1'b1;
        op_num  <= bus.b_number;
        op_sel  <= bus.b_selection;
        op_mode <= bus.b_mode;
      end

      if (state == CAPTURE) begin
        rsp_d1   <= dp_digit1;
        rsp_d0   <= dp_digit0;
        rsp_warn <= dp_warning;
        rsp_id_q <= op_id;
        if (op_id) begin
          cnt_b <= cnt_nx;
          if (cnt_nx == LIMIT) blk_b <= 1'b1;
        end else begin
          cnt_a <= cnt_nx;
          if (cnt_nx == LIMIT) blk_a <= 1'b1;
        end
      end

      if (rsp_fire) last_served <= rsp_id_q;

      if (state == CLEAR) begin
        cnt_a <= '0;
        cnt_b <= '0;
        blk_a <= 1'b0;
        blk_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lab3_2_sched.sv
// Directed bench for lab3_2_sched: single op, backpressure, round-robin,
// lockout, clear during an op, clear vs request, and async reset mid-op.
module tb_lab3_2_sched;
  logic       CLK = 1'b0;
  logic       clear_n = 1'b0;
  logic       clr_req = 1'b0;
  logic       clr_done;
  logic       dp_en, dp_clear, dp_selection, dp_mode;
  logic [3:0] dp_number;
  logic [7:0] dp_digit1 = '0;
  logic [7:0] dp_digit0 = '0;
  logic       dp_warning = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  lab3_2_sched_if bus();

  lab3_2_sched #(.ERR_LIMIT(3)) dut (
    .CLK          (CLK),
    .clear_n      (clear_n),
    .bus          (bus.slave),
    .clr_req      (clr_req),
    .clr_done     (clr_done),
    .dp_en        (dp_en),
    .dp_clear     (dp_clear),
    .dp_selection (dp_selection),
    .dp_mode      (dp_mode),
    .dp_number    (dp_number),
    .dp_digit1    (dp_digit1),
    .dp_digit0    (dp_digit0),
    .dp_warning   (dp_warning)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.a_valid = 0; bus.a_number = 0; bus.a_selection = 0; bus.a_mode = 0;
    bus.b_valid = 0; bus.b_number = 0; bus.b_selection = 0; bus.b_mode = 0;
    bus.rsp_ready = 0;

    // Reset values
    #3;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_digit1", bus.rsp_digit1, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_a_blocked", bus.a_blocked, 0);
    chk("rst_b_blocked", bus.b_blocked, 0);
    chk("rst_dp_en", dp_en, 0);
    chk("rst_clr_done", clr_done, 0);
    tick(); tick();
    clear_n = 1;

    // Single op from A: 5, prime, next -> datapath answers 11/5/0
    bus.a_valid = 1; bus.a_number = 5; bus.a_selection = 0; bus.a_mode = 1;
    #1;
    chk("single_a_ready", bus.a_ready, 1);
    chk("single_b_ready", bus.b_ready, 0);
    tick();
    bus.a_valid = 0; dp_digit1 = 8'd11; dp_digit0 = 8'd5; dp_warning = 0;
    #1;
    chk("issue_dp_en", dp_en, 1);
    chk("issue_dp_number", dp_number, 5);
    chk("issue_dp_mode", dp_mode, 1);
    chk("issue_dp_sel", dp_selection, 0);
    chk("issue_dp_clear", dp_clear, 0);
    chk("issue_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("capture_dp_en", dp_en, 0);
    chk("capture_dp_number", dp_number, 0);
    chk("capture_dp_mode", dp_mode, 0);
    chk("capture_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("resp_valid", bus.rsp_valid, 1);
    chk("resp_id", bus.rsp_id, 0);
    chk("resp_digit1", bus.rsp_digit1, 11);
    chk("resp_digit0", bus.rsp_digit0, 5);
    chk("resp_warning", bus.rsp_warning, 0);

    // Backpressure: response held, no new ops, datapath outputs changing
    bus.a_valid = 1; bus.b_valid = 1; bus.a_number = 3; bus.b_number = 9;
    dp_digit1 = 8'h22; dp_digit0 = 8'h33;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_digit1", bus.rsp_digit1, 11);
      chk("bp_digit0", bus.rsp_digit0, 5);
      chk("bp_dp_en", dp_en, 0);
      chk("bp_a_ready", bus.a_ready, 0);
      chk("bp_b_ready", bus.b_ready, 0);
      tick();
    end
    bus.rsp_ready = 1;
    tick();

    // Contention: A served last, so B, A, B, A
    for (int op = 0; op < 4; op++) begin
      logic exp_b;
      exp_b = (op % 2 == 0);
      #1;
      chk("rr_a_ready", bus.a_ready, !exp_b);
      chk("rr_b_ready", bus.b_ready, exp_b);
      tick();
      chk("rr_issue_dp_en", dp_en, 1);
      chk("rr_issue_number", dp_number, exp_b ? 9 : 3);
      tick();
      chk("rr_capture_dp_en", dp_en, 0);
      tick();
      chk("rr_resp_dp_en", dp_en, 0);
      chk("rr_resp_valid", bus.rsp_valid, 1);
      chk("rr_resp_id", bus.rsp_id, exp_b);
      tick();
    end

    // Lockout: three warning ops from B
    bus.a_valid = 0; bus.b_number = 4; bus.b_selection = 0; dp_warning = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_b_ready", bus.b_ready, 1);
      tick(); tick(); tick();
      chk("lock_rsp_valid", bus.rsp_valid, 1);
      chk("lock_rsp_warning", bus.rsp_warning, 1);
      chk("lock_b_blocked", bus.b_blocked, (k == 2));
      tick();
    end
    bus.a_valid = 1; bus.a_number = 6;
    #1;
    chk("blocked_b_ready", bus.b_ready, 0);
    chk("blocked_a_ready", bus.a_ready, 1);

    // A served while B blocked; clr_req pulsed during A's CAPTURE
    tick();
    dp_warning = 0;
    tick();
    clr_req = 1;
    tick();
    clr_req = 0;
    #1;
    chk("clr_resp_valid", bus.rsp_valid, 1);
    chk("clr_resp_id", bus.rsp_id, 0);
    chk("clr_resp_warning", bus.rsp_warning, 0);
    chk("clr_b_still_blocked", bus.b_blocked, 1);
    tick();
    chk("clr_pend_a_ready", bus.a_ready, 0);
    chk("clr_pend_b_ready", bus.b_ready, 0);
    chk("clr_pend_dp_en", dp_en, 0);
    tick();
    chk("clear_dp_en", dp_en, 1);
    chk("clear_dp_clear", dp_clear, 1);
    chk("clear_dp_number", dp_number, 0);
    chk("clear_clr_done", clr_done, 0);
    tick();
    chk("post_clear_done", clr_done, 1);
    chk("post_clear_b_blocked", bus.b_blocked, 0);
    chk("post_clear_b_ready", bus.b_ready, 1);
    chk("post_clear_a_ready", bus.a_ready, 0);

    // B accepted; async reset during its ISSUE cycle
    tick();
    chk("pre_rst_dp_en", dp_en, 1);
    chk("pre_rst_dp_number", dp_number, 4);
    #2;
    clear_n = 0;
    #1;
    chk("async_dp_en", dp_en, 0);
    chk("async_dp_number", dp_number, 0);
    chk("async_rsp_valid", bus.rsp_valid, 0);
    chk("async_clr_done", clr_done, 0);
    tick();
    clear_n = 1;
    #1;
    chk("post_rst_a_ready", bus.a_ready, 1);
    chk("post_rst_b_ready", bus.b_ready, 0);

    // Clear request together with valid requests in IDLE: clear wins
    clr_req = 1;
    #1;
    chk("clr_vs_req_a_ready", bus.a_ready, 0);
    chk("clr_vs_req_b_ready", bus.b_ready, 0);
    tick();
    clr_req = 0;
    #1;
    chk("clr_vs_req_dp_clear", dp_clear, 1);
    tick();
    chk("clr_vs_req_done", clr_done, 1);
    chk("clr_vs_req_a_ready2", bus.a_ready, 1);
    tick();
    chk("first_grant_dp_en", dp_en, 1);
    chk("first_grant_number", dp_number, 6);
    tick(); tick();
    chk("first_grant_rsp_valid", bus.rsp_valid, 1);
    chk("first_grant_rsp_id", bus.rsp_id, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
